// File: rtl/amstrad_mem_arbiter_if.sv
// Bus bundle for amstrad_mem_arbiter.
// Carries the three requester handshakes (video, CPU, loader), the single
// RAM controller command/response port and the current-owner indication.
//   slave  : arbiter view (takes requests and RAM responses, drives acks,
//            read data, the RAM command and grant)
//   master : environment view (requesters plus RAM controller)
interface amstrad_mem_arbiter_if;
  // video fetch path (word reads)
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [15:0] vid_dout;
  logic        vid_ack;
  // CPU memory path (byte access, MMU-translated address)
  logic        cpu_req;
  logic        cpu_we;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  // ROM/disk loader (byte writes)
  logic        ld_req;
  logic [22:0] ld_addr;
  logic [7:0]  ld_din;
  logic        ld_ack;
  // RAM controller port
  logic        ram_req;
  logic        ram_we;
  logic [22:0] ram_addr;
  logic [1:0]  ram_be;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        ram_ready;
  // current owner: 0=none 1=video 2=CPU 3=loader
  logic [1:0]  grant;

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  ld_req, ld_addr, ld_din,
    input  ram_dout, ram_ready,
    output vid_dout, vid_ack,
    output cpu_dout, cpu_ack,
    output ld_ack,
    output ram_req, ram_we, ram_addr, ram_be, ram_din,
    output grant
  );

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output ld_req, ld_addr, ld_din,
    output ram_dout, ram_ready,
    input  vid_dout, vid_ack,
    input  cpu_dout, cpu_ack,
    input  ld_ack,
    input  ram_req, ram_we, ram_addr, ram_be, ram_din,
    input  grant
  );
endinterface

// File: rtl/amstrad_mem_arbiter.sv
// amstrad_mem_arbiter
// Shares the single 16-bit external RAM port between the video fetch path,
// the CPU memory path and the ROM/disk loader. Fixed priority
// video > CPU > loader; every transaction walks IDLE -> ISSUE -> WAIT -> DONE
// (4 cycles minimum), and the owner's ack is a one-cycle strobe in DONE.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (RAM controller shares the net)
//   bus      amstrad_mem_arbiter_if.slave: requester handshakes, RAM
//            command/response port, grant
//
// Parameters:
//   VID_BASE   byte base address added to the video word address
//   LD_STARVE  grants a pending loader may lose before it is promoted
//
// Build option:
//   ARB_LD_STARVE_EN  when defined, a pending loader that has lost
//                     LD_STARVE grants beats the CPU (never video).
//                     Undefined: strict priority, no counter.
module amstrad_mem_arbiter #(
  parameter logic [22:0] VID_BASE  = 23'h000000,
  parameter int          LD_STARVE = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  amstrad_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_VID  = 2'd1,
    G_CPU  = 2'd2,
    G_LD   = 2'd3
  } owner_t;

  typedef struct packed {
    logic [22:0] addr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] din;
  } ram_cmd_t;

  if (LD_STARVE < 1) begin : g_bad_cfg
    $error("amstrad_mem_arbiter: LD_STARVE must be at least 1");
  end

  state_t   state;
  owner_t   owner;
  ram_cmd_t cmd;
  logic     ram_req_q;
  logic     vid_ack_q, cpu_ack_q, ld_ack_q;
  logic [15:0] vid_dout_q;
  logic [7:0]  cpu_dout_q;

  // ---------------------------------------------------------------------
  // Loader promotion
  // ---------------------------------------------------------------------
  logic ld_promote;

`ifdef ARB_LD_STARVE_EN
  localparam int SW = $clog2(LD_STARVE + 1);
  logic [SW-1:0] starve;

  assign ld_promote = (starve == SW'(LD_STARVE));
`else
  assign ld_promote = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Arbitration and command formation (only consumed in IDLE)
  // ---------------------------------------------------------------------
  owner_t   win;
  ram_cmd_t win_cmd;

  always_comb begin
    win = G_NONE;
    if (bus.vid_req)                    win = G_VID;
    else if (bus.ld_req && ld_promote)  win = G_LD;
    else if (bus.cpu_req)               win = G_CPU;
    else if (bus.ld_req)                win = G_LD;
  end

  always_comb begin
    win_cmd = '0;
    case (win)
      G_VID: begin
        // word address -> byte address, wraps modulo 2^23
        win_cmd.addr = VID_BASE + {7'd0, bus.vid_addr, 1'b0};
        win_cmd.be   = 2'b11;
      end
      G_CPU: begin
        win_cmd.addr = bus.cpu_addr;
        win_cmd.we   = bus.cpu_we;
        if (bus.cpu_we) begin
          // byte write: replicate data, enable the lane picked by addr[0]
          win_cmd.be  = bus.cpu_addr[0] ? 2'b10 : 2'b01;
          win_cmd.din = {bus.cpu_din, bus.cpu_din};
        end else begin
          win_cmd.be  = 2'b11;
        end
      end
      G_LD: begin
        win_cmd.addr = bus.ld_addr;
        win_cmd.we   = 1'b1;
        win_cmd.be   = bus.ld_addr[0] ? 2'b10 : 2'b01;
        win_cmd.din  = {bus.ld_din, bus.ld_din};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Transaction FSM; every output is a register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= G_NONE;
      cmd        <= '0;
      ram_req_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      ld_ack_q   <= 1'b0;
      vid_dout_q <= '0;
      cpu_dout_q <= '0;
    end else begin
      // acks are strobes: only the WAIT->DONE edge raises one
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      ld_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          owner <= win;
          if (win != G_NONE) begin
            cmd       <= win_cmd;
            ram_req_q <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.ram_ready) begin
            ram_req_q <= 1'b0;
            state     <= DONE;
            case (owner)
              G_VID: begin
                vid_dout_q <= bus.ram_dout;
                vid_ack_q  <= 1'b1;
              end
              G_CPU: begin
                cpu_ack_q <= 1'b1;
                if (!cmd.we)
                  cpu_dout_q <= cmd.addr[0] ? bus.ram_dout[15:8] : bus.ram_dout[7:0];
              end
              G_LD:    ld_ack_q <= 1'b1;
              default: ;
            endcase
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_LD_STARVE_EN
  // Counts grants lost by a waiting loader; saturates at LD_STARVE, and a
  // loader grant or a dropped ld_req clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve <= '0;
    else if (!bus.ld_req || (state == IDLE && win == G_LD))
      starve <= '0;
    else if (state == IDLE && (win == G_VID || win == G_CPU) && !ld_promote)
      starve <= starve + 1'b1;
  end
`endif

  assign bus.ram_req  = ram_req_q;
  assign bus.ram_we   = cmd.we;
  assign bus.ram_addr = cmd.addr;
  assign bus.ram_be   = cmd.be;
  assign bus.ram_din  = cmd.din;
  assign bus.vid_ack  = vid_ack_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.ld_ack   = ld_ack_q;
  assign bus.vid_dout = vid_dout_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.grant    = owner;

endmodule

// File: doc/amstrad_mem_arbiter.md
Name: amstrad_mem_arbiter

Overview:
- Shares the single 16-bit external RAM port between three requesters: the video fetch path, the CPU memory path (MMU-translated 23-bit byte address) and the ROM/disk loader.
- Sits between the motherboard's memory/vram buses and the RAM controller.
- Fixed priority is video > CPU > loader, with optional loader anti-starvation.
- Each requester gets a level-request / single-cycle-ack handshake.

Parameters:
- VID_BASE, 23'h000000: byte base address that the video word address is offset from.
- LD_STARVE, 8: number of grants lost by a pending loader request before it is promoted (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  video word read request, level, held until vid_ack
- vid_addr  in  15  video word address
- vid_dout  out  16  video read data, valid while vid_ack=1
- vid_ack  out  1  one-cycle completion strobe
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  23  CPU byte address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read byte, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion strobe
- ld_req  in  1  loader write request, level
- ld_addr  in  23  loader byte address
- ld_din  in  8  loader write data
- ld_ack  out  1  one-cycle completion strobe
- ram_req  out  1  RAM command valid, held until ram_ready
- ram_we  out  1  RAM write
- ram_addr  out  23  RAM byte address; bit0 is ignored for word reads
- ram_be  out  2  byte enables, {hi,lo}
- ram_din  out  16  RAM write data
- ram_dout  in  16  RAM read data, valid with ram_ready
- ram_ready  in  1  one-cycle completion from the RAM controller
- grant  out  2  current owner: 0=none, 1=video, 2=CPU, 3=loader

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - ram_req, ram_we and all acks are 0.
  - ram_addr, ram_din, ram_be, vid_dout, cpu_dout and grant are 0.
  - Starve counter is 0.
  - Any in-flight transaction is abandoned with no ack; the RAM controller is reset by the same net.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples requests. Winner is video if vid_req, else CPU if cpu_req, else loader if ld_req.
  - Latches the command registers and grant, then moves to ISSUE. With no request it stays in IDLE and grant=0.
- ISSUE:
  - Drives ram_req=1 with the latched command and moves to WAIT.
  - Latency from request sampled in IDLE (cycle 0) to ram_req high is cycle 1.
- WAIT:
  - ram_req and the command are held stable until ram_ready=1.
  - On ram_ready: ram_req drops at the same edge, read data is captured, state goes to DONE. ram_ready may arrive in the first WAIT cycle.
- DONE:
  - The owner's ack is high for exactly one cycle with its data valid; grant is kept.
  - Next state is IDLE. The requester drops req at the edge where it sees ack; a req still high in IDLE is a new transaction.
- Command formation:
  - Video: ram_addr = VID_BASE + {vid_addr,1'b0} (23-bit, modulo 2^23), ram_we=0, ram_be=2'b11, vid_dout=ram_dout.
  - CPU read: ram_addr=cpu_addr, ram_be=2'b11. cpu_dout = cpu_addr[0] ? ram_dout[15:8] : ram_dout[7:0].
  - CPU or loader write: ram_we=1, ram_din={d,d}. ram_be = addr[0] ? 2'b10 : 2'b01.
- Requests arriving during ISSUE, WAIT or DONE wait for the next IDLE. No preemption of an issued command.
- Simultaneous requests in IDLE resolve by priority only. Losers remain pending, with no ack and no data change.
- vid_dout and cpu_dout hold their last captured value outside ack cycles.
- Minimum transaction length is 4 cycles (IDLE, ISSUE, WAIT, DONE).

Optional Feature:
- Macro: ARB_LD_STARVE_EN.
- When defined:
  - The starve counter increments each IDLE grant given to video or CPU while ld_req=1, saturating at LD_STARVE.
  - At LD_STARVE, the loader beats the CPU (but not video) at the next IDLE.
  - The counter clears on loader grant or whenever ld_req=0.
- When undefined: strict priority, no counter logic.

Test Plan:
- Reset mid-WAIT (CPU read pending, reset_n low for 1 cycle): ram_req and cpu_ack go low immediately, grant=0, and no ack follows after release.
- cpu_req read at addr 23'h012345, ram_ready 3 cycles after ram_req, ram_dout=16'hBEEF: ram_be=2'b11, cpu_ack a single cycle, cpu_dout=8'hBE.
- CPU write at 23'h000100 with data 8'h5A: ram_we=1, ram_be=2'b01, ram_din=16'h5A5A, cpu_ack after ram_ready.
- vid_req and cpu_req raised in the same cycle, vid_addr=15'h7FFF, VID_BASE=0: video is served first at ram_addr=23'h00FFFE, then the CPU; each ack fires once.
- ram_ready returned in the first WAIT cycle: ack on the following cycle and a 4-cycle total.
- ARB_LD_STARVE_EN, LD_STARVE=8, continuous cpu_req and ld_req: the loader is granted at the 9th arbitration; with the macro undefined, the loader is never granted while cpu_req stays high.
